mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin on ties, grant held for the whole
// burst while the owner keeps cs asserted, no combinational path from ack to mem_*.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // Requester 0 (instruction cache controller)
    input  logic                  s0_cs_i,
    input  logic                  s0_we_i,
    input  logic [ADDR_WIDTH-1:0] s0_addr_i,
    input  logic [DATA_WIDTH-1:0] s0_data_i,
    output logic [DATA_WIDTH-1:0] s0_data_o,
    output logic                  s0_ack_o,
    // Requester 1 (data cache controller)
    input  logic                  s1_cs_i,
    input  logic                  s1_we_i,
    input  logic [ADDR_WIDTH-1:0] s1_addr_i,
    input  logic [DATA_WIDTH-1:0] s1_data_i,
    output logic [DATA_WIDTH-1:0] s1_data_o,
    output logic                  s1_ack_o,
    // Shared memory
    output logic                  mem_cs_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ack_i,
    // Ownership and debug visibility
    output logic [1:0]            gnt_o,
    output logic                  last_o,
    output logic [1:0]            state_o
);

    // Handshake: a requester holds cs (with stable we/addr/data) for each word
    // until its ack pulses; ack is only forwarded to the current owner while its
    // cs is high, so stray or late memory acks are silently dropped.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } state_t;

    state_t state, next_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            last_o <= 1'b1;
        end else begin
            state <= next_state;
            if (next_state == S_GNT0)
                last_o <= 1'b0;
            else if (next_state == S_GNT1)
                last_o <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (s0_cs_i && s1_cs_i)
                    next_state = last_o ? S_GNT0 : S_GNT1;
                else if (s0_cs_i)
                    next_state = S_GNT0;
                else if (s1_cs_i)
                    next_state = S_GNT1;
            end
            S_GNT0: begin
                if (!s0_cs_i)
                    next_state = s1_cs_i ? S_GNT1 : S_IDLE;
            end
            S_GNT1: begin
                if (!s1_cs_i)
                    next_state = s0_cs_i ? S_GNT0 : S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Request mux is driven purely by the registered owner and requester inputs.
    always_comb begin
        mem_cs_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        gnt_o      = 2'b00;
        case (state)
            S_GNT0: begin
                mem_cs_o   = s0_cs_i;
                mem_we_o   = s0_we_i;
                mem_addr_o = s0_addr_i;
                mem_data_o = s0_data_i;
                gnt_o      = 2'b01;
            end
            S_GNT1: begin
                mem_cs_o   = s1_cs_i;
                mem_we_o   = s1_we_i;
                mem_addr_o = s1_addr_i;
                mem_data_o = s1_data_i;
                gnt_o      = 2'b10;
            end
            default: ;
        endcase
    end

    assign s0_ack_o  = mem_ack_i && (state == S_GNT0) && s0_cs_i;
    assign s1_ack_o  = mem_ack_i && (state == S_GNT1) && s1_cs_i;
    assign s0_data_o = mem_data_i;
    assign s1_data_o = mem_data_i;
    assign state_o   = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-requester burst, tie round-robin,
// burst atomicity, turnaround, stray ack and asynchronous reset mid-burst.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          s0_cs_i, s0_we_i, s1_cs_i, s1_we_i;
    logic [AW-1:0] s0_addr_i, s1_addr_i;
    logic [DW-1:0] s0_data_i, s1_data_i;
    logic [DW-1:0] s0_data_o, s1_data_o;
    logic          s0_ack_o, s1_ack_o;
    logic          mem_cs_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [DW-1:0] mem_data_i;
    logic          mem_ack_i;
    logic [1:0]    gnt_o;
    logic          last_o;
    logic [1:0]    state_o;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s0_cs_i    (s0_cs_i),
        .s0_we_i    (s0_we_i),
        .s0_addr_i  (s0_addr_i),
        .s0_data_i  (s0_data_i),
        .s0_data_o  (s0_data_o),
        .s0_ack_o   (s0_ack_o),
        .s1_cs_i    (s1_cs_i),
        .s1_we_i    (s1_we_i),
        .s1_addr_i  (s1_addr_i),
        .s1_data_i  (s1_data_i),
        .s1_data_o  (s1_data_o),
        .s1_ack_o   (s1_ack_o),
        .mem_cs_o   (mem_cs_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i),
        .gnt_o      (gnt_o),
        .last_o     (last_o),
        .state_o    (state_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with live inputs: everything must stay quiet
        rst = 1'b1;
        s0_cs_i = 1'b1; s0_we_i = 1'b1; s0_addr_i = 32'h55; s0_data_i = 32'h66;
        s1_cs_i = 1'b1; s1_we_i = 1'b1; s1_addr_i = 32'h77; s1_data_i = 32'h88;
        mem_ack_i = 1'b1; mem_data_i = '0;
        tick();
        tick();
        chk("rst_gnt",    32'(gnt_o), 0);
        chk("rst_state",  32'(state_o), 0);
        chk("rst_last",   32'(last_o), 1);
        chk("rst_mem_cs", 32'(mem_cs_o), 0);
        chk("rst_mem_we", 32'(mem_we_o), 0);
        chk("rst_addr",   mem_addr_o, 0);
        chk("rst_mdata",  mem_data_o, 0);
        chk("rst_ack0",   32'(s0_ack_o), 0);
        chk("rst_ack1",   32'(s1_ack_o), 0);
        s0_cs_i = 1'b0; s0_we_i = 1'b0; s0_addr_i = '0; s0_data_i = '0;
        s1_cs_i = 1'b0; s1_we_i = 1'b0; s1_addr_i = '0; s1_data_i = '0;
        mem_ack_i = 1'b0;
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'(gnt_o), 0);

        // Single requester: s0 reads 4 words, memory acks 2 cycles after each request
        s0_cs_i = 1'b1; s0_addr_i = 32'h100;
        #1 chk("t1_latency_gnt", 32'(gnt_o), 0);
        chk("t1_latency_cs", 32'(mem_cs_o), 0);
        tick();
        chk("t1_gnt", 32'(gnt_o), 32'h1);
        ack_cnt = 0;
        for (int w = 0; w < 4; w++) begin
            s0_addr_i = 32'h100 + 32'(4 * w);
            #1 chk("t1_addr", mem_addr_o, 32'h100 + 32'(4 * w));
            chk("t1_mem_cs", 32'(mem_cs_o), 1);
            tick();
            chk("t1_no_early_ack", 32'(s0_ack_o), 0);
            tick();
            mem_ack_i = 1'b1; mem_data_i = 32'hD000 + 32'(w);
            #1 chk("t1_ack0", 32'(s0_ack_o), 1);
            chk("t1_ack1", 32'(s1_ack_o), 0);
            chk("t1_rdata", s0_data_o, 32'hD000 + 32'(w));
            if (s0_ack_o) ack_cnt++;
            tick();
            mem_ack_i = 1'b0;
        end
        chk("t1_ack_count", 32'(ack_cnt), 4);
        s0_cs_i = 1'b0;
        tick();
        chk("t1_release", 32'(gnt_o), 0);
        chk("t1_idle_addr", mem_addr_o, 0);
        chk("t1_last", 32'(last_o), 0);

        // Tie after reset goes to s0, then round-robin gives the next tie to s1
        rst = 1'b1;
        #1 rst = 1'b0;
        chk("t2_rst_last", 32'(last_o), 1);
        tick();
        s0_cs_i = 1'b1; s0_addr_i = 32'h300;
        s1_cs_i = 1'b1; s1_addr_i = 32'h400;
        tick();
        chk("t2_tie1_gnt", 32'(gnt_o), 32'h1);
        chk("t2_tie1_addr", mem_addr_o, 32'h300);
        s0_cs_i = 1'b0; s1_cs_i = 1'b0;
        tick();
        chk("t2_idle", 32'(gnt_o), 0);
        s0_cs_i = 1'b1; s1_cs_i = 1'b1;
        tick();
        chk("t2_tie2_gnt", 32'(gnt_o), 32'h2);
        chk("t2_tie2_addr", mem_addr_o, 32'h400);
        s1_cs_i = 1'b0;
        tick();
        chk("t2_handoff_no_idle", 32'(gnt_o), 32'h1);
        chk("t2_handoff_last", 32'(last_o), 0);
        s0_cs_i = 1'b0;
        tick();
        chk("t2_end_idle", 32'(gnt_o), 0);

        // Burst atomicity: s1 write-back of 4 words while s0 requests throughout
        s0_cs_i = 1'b1; s0_we_i = 1'b0; s0_addr_i = 32'h500;
        s1_cs_i = 1'b1; s1_we_i = 1'b1; s1_addr_i = 32'h200; s1_data_i = 32'hB0;
        tick();
        for (int w = 0; w < 4; w++) begin
            s1_addr_i = 32'h200 + 32'(4 * w); s1_data_i = 32'hB0 + 32'(w);
            #1 chk("t3_gnt", 32'(gnt_o), 32'h2);
            chk("t3_addr", mem_addr_o, 32'h200 + 32'(4 * w));
            chk("t3_we", 32'(mem_we_o), 1);
            chk("t3_wdata", mem_data_o, 32'hB0 + 32'(w));
            mem_ack_i = 1'b1;
            #1 chk("t3_ack1", 32'(s1_ack_o), 1);
            chk("t3_ack0_blocked", 32'(s0_ack_o), 0);
            tick();
            mem_ack_i = 1'b0;
        end
        s1_cs_i = 1'b0; s1_we_i = 1'b0;
        tick();
        chk("t3_s0_after", 32'(gnt_o), 32'h1);
        chk("t3_s0_addr", mem_addr_o, 32'h500);
        chk("t3_s0_we", 32'(mem_we_o), 0);
        s0_cs_i = 1'b0;
        tick();

        // Turnaround: one-cycle cs gap in s1 hands the grant to pending s0
        s1_cs_i = 1'b1; s1_we_i = 1'b1; s1_addr_i = 32'h600;
        tick();
        chk("t4_wb_gnt", 32'(gnt_o), 32'h2);
        s0_cs_i = 1'b1; s0_addr_i = 32'h700;
        tick();
        chk("t4_wb_hold", 32'(gnt_o), 32'h2);
        s1_cs_i = 1'b0;
        mem_ack_i = 1'b1;
        #1 chk("t4_gap_ack_dropped", 32'(s1_ack_o), 0);
        mem_ack_i = 1'b0;
        tick();
        s1_cs_i = 1'b1; s1_we_i = 1'b0; s1_addr_i = 32'h640;
        #1 chk("t4_gap_to_s0", 32'(gnt_o), 32'h1);
        chk("t4_s0_addr", mem_addr_o, 32'h700);
        mem_ack_i = 1'b1;
        #1 chk("t4_s0_ack", 32'(s0_ack_o), 1);
        chk("t4_s1_wait_ack", 32'(s1_ack_o), 0);
        tick();
        mem_ack_i = 1'b0;
        s0_cs_i = 1'b0;
        tick();
        chk("t4_fill_gnt", 32'(gnt_o), 32'h2);
        chk("t4_fill_addr", mem_addr_o, 32'h640);
        s1_cs_i = 1'b0;
        tick();

        // Stray ack in idle is dropped and the state does not move
        mem_ack_i = 1'b1; mem_data_i = 32'hEE;
        #1 chk("t5_ack0", 32'(s0_ack_o), 0);
        chk("t5_ack1", 32'(s1_ack_o), 0);
        tick();
        chk("t5_state", 32'(state_o), 0);
        chk("t5_gnt", 32'(gnt_o), 0);
        mem_ack_i = 1'b0;

        // Asynchronous reset in the middle of an s1 fill
        s1_cs_i = 1'b1; s1_addr_i = 32'h800;
        tick();
        chk("t6_gnt_before", 32'(gnt_o), 32'h2);
        chk("t6_cs_before", 32'(mem_cs_o), 1);
        #2 rst = 1'b1;
        #1 chk("t6_async_cs", 32'(mem_cs_o), 0);
        chk("t6_async_gnt", 32'(gnt_o), 0);
        mem_ack_i = 1'b1;
        #1 chk("t6_late_ack", 32'(s1_ack_o), 0);
        mem_ack_i = 1'b0;
        tick();
        rst = 1'b0;
        #1 chk("t6_no_gnt_yet", 32'(gnt_o), 0);
        tick();
        chk("t6_regrant", 32'(gnt_o), 32'h2);
        chk("t6_regrant_addr", mem_addr_o, 32'h800);
        s1_cs_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
